// File: rtl/keccak_absorb_buf.sv
// Packs 64-bit message words into one SHAKE rate block, applies pad10*1 with DS, and hands 1600-bit blocks downstream.
// Block is valid the cycle after its final word is accepted; no words are taken while a block waits on blk_ready.
module keccak_absorb_buf #(
  parameter int          W  = 64,
  parameter logic [7:0]  DS = 8'h1F
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  input  logic [3:0]    in_bytes,
  output logic          blk_valid,
  input  logic          blk_ready,
  output logic [1599:0] blk_data,
  output logic          blk_last
);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [4:0]          cnt, cnt_nxt;
  logic [4:0]          rate_l, rate_nxt, rate_eff;
  logic                pend_pad, pend_nxt;
  logic                mid_msg, mid_nxt;
  logic                last_q, last_nxt;
  logic [24:0][W-1:0]  lanes, lanes_nxt;
  logic                acc, hs, at_end;
  logic [3:0]          nb;
  logic [W-1:0]        masked;

  // cnt returns to 0 at every block boundary, so mid_msg separates a new message from a continuation
  always_comb begin
    rate_eff = (cnt == 5'd0 && !mid_msg) ? (mode ? 5'd17 : 5'd21) : rate_l;
    at_end   = (cnt == rate_eff - 5'd1);
    acc      = in_valid && (state == FILL);
    hs       = blk_ready && (state == FULL);
    nb       = (!in_last || in_bytes >= 4'd8) ? 4'd8 : in_bytes;
    masked   = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < nb) masked[8*k +: 8] = in_data[8*k +: 8];
    end
  end

  always_comb begin
    lanes_nxt = lanes;
    cnt_nxt   = cnt;
    rate_nxt  = rate_l;
    pend_nxt  = pend_pad;
    mid_nxt   = mid_msg;
    last_nxt  = last_q;
    if (acc) begin
      rate_nxt       = rate_eff;
      lanes_nxt[cnt] = masked;
      if (!in_last) begin
        mid_nxt = 1'b1;
        if (!at_end) cnt_nxt = cnt + 5'd1;
        else         last_nxt = 1'b0;
      end else begin
        mid_nxt = 1'b0;
        if (nb < 4'd8) begin
          lanes_nxt[cnt][{nb[2:0], 3'b000} +: 8] ^= DS;
          lanes_nxt[rate_eff - 5'd1][63:56]      ^= 8'h80;
          last_nxt = 1'b1;
        end else if (!at_end) begin
          lanes_nxt[cnt + 5'd1][7:0]         ^= DS;
          lanes_nxt[rate_eff - 5'd1][63:56]  ^= 8'h80;
          last_nxt = 1'b1;
        end else begin
          // message exactly fills the block: padding goes into a block of its own
          last_nxt = 1'b0;
          pend_nxt = 1'b1;
        end
      end
    end else if (hs) begin
      lanes_nxt = '0;
      cnt_nxt   = 5'd0;
      last_nxt  = 1'b0;
      if (pend_pad) begin
        lanes_nxt[0][7:0]                = DS;
        lanes_nxt[rate_l - 5'd1][63:56]  = 8'h80;
        last_nxt = 1'b1;
        pend_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FILL;
      cnt      <= 5'd0;
      rate_l   <= 5'd21;
      pend_pad <= 1'b0;
      mid_msg  <= 1'b0;
      last_q   <= 1'b0;
      lanes    <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rate_l   <= rate_nxt;
      pend_pad <= pend_nxt;
      mid_msg  <= mid_nxt;
      last_q   <= last_nxt;
      lanes    <= lanes_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (acc && (in_last || at_end)) state_nxt = FULL;
      FULL:    if (hs && !pend_pad)            state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    in_ready  = (state == FILL);
    blk_valid = (state == FULL);
    blk_data  = lanes;
    blk_last  = last_q;
  end

endmodule

// File: tb/tb_keccak_absorb_buf.sv
// Directed and randomized checks of keccak_absorb_buf against hand-computed blocks and a byte-level pad10*1 model.
module tb_keccak_absorb_buf;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_data = '0;
  logic          in_last = 1'b0;
  logic [3:0]    in_bytes = '0;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
  logic [1599:0] blk_data;
  logic          blk_last;

  int checks = 0;
  int failures = 0;

  logic [7:0]    msg[$];
  logic [1599:0] exp_dat[$];
  logic          exp_last[$];

  keccak_absorb_buf #(.W(64), .DS(8'h1F)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last)
  );

  always #5 clk = ~clk;

  function automatic int diff_lane(input logic [1599:0] a, input logic [1599:0] b);
    for (int i = 0; i < 25; i++) if (a[64*i +: 64] !== b[64*i +: 64]) return i;
    return 0;
  endfunction

  task automatic send_word(input logic [63:0] d, input logic l, input logic [3:0] b,
                           input logic m, output bit ok);
    int n; logic r;
    in_valid = 1'b1; in_data = d; in_last = l; in_bytes = b; mode = m;
    n = 0; ok = 1'b0;
    while (!ok && n < 100) begin
      r = in_ready;
      @(posedge clk); #1;
      n++;
      if (r) ok = 1'b1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_blk(output bit ok);
    int n;
    n = 0;
    while (!blk_valid && n < 100) begin @(posedge clk); #1; n++; end
    ok = blk_valid;
  endtask

  task automatic take_blk;
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
  endtask

  // byte-level SHAKE padding: DS after message, 0x80 in the final byte of the final block
  task automatic model(input int rl);
    int rb, n, nblk, idx;
    logic [7:0] v;
    logic [1599:0] d;
    rb = rl * 8; n = msg.size(); nblk = n / rb + 1;
    for (int b = 0; b < nblk; b++) begin
      d = '0;
      for (int i = 0; i < rb; i++) begin
        idx = b * rb + i;
        v = (idx < n) ? msg[idx] : 8'h00;
        if (idx == n) v = v ^ 8'h1F;
        if (idx == nblk * rb - 1) v = v ^ 8'h80;
        d[8*i +: 8] = v;
      end
      exp_dat.push_back(d);
      exp_last.push_back(b == nblk - 1);
    end
  endtask

  task automatic test_reset;
    logic [24:0][63:0] e;
    bit ok, good;
    int k;
    rst = 1'b0;
    repeat (5) begin
      in_valid = 1'($urandom_range(0, 1)); in_data = {$urandom(), $urandom()};
      in_last = 1'($urandom_range(0, 1)); in_bytes = 4'($urandom_range(0, 8));
      mode = 1'($urandom_range(0, 1)); blk_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    checks++;
    if (in_ready !== 1'b1 || blk_valid !== 1'b0 || blk_last !== 1'b0)
      begin failures++; $display("FAIL reset_ctl got rdy=%b vld=%b last=%b exp 1 0 0", in_ready, blk_valid, blk_last); end
    checks++;
    if (blk_data !== '0) begin
      failures++; k = diff_lane(blk_data, '0);
      $display("FAIL reset_data lane=%0d got=%h exp=0", k, blk_data[64*k +: 64]);
    end
    in_valid = 1'b0; blk_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    good = 1'b1;
    for (int i = 0; i < 3; i++) begin send_word(64'hDEAD_0000_0000_0000 | 64'(i), 1'b0, 4'd8, 1'b0, ok); good &= ok; end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || blk_valid !== 1'b0)
      begin failures++; $display("FAIL reset_async got rdy=%b vld=%b exp 1 0", in_ready, blk_valid); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    send_word(64'h1122334455667788, 1'b1, 4'd8, 1'b1, ok); good &= ok;
    wait_blk(ok); good &= ok;
    checks++;
    if (!good) begin failures++; $display("FAIL reset_hs got=0 exp=1 (handshake timeout)"); end
    e = '0; e[0] = 64'h1122334455667788; e[1] = 64'h1F; e[16] = 64'h8000_0000_0000_0000;
    checks++;
    if (blk_data !== e || blk_last !== 1'b1) begin
      failures++; k = diff_lane(blk_data, e);
      $display("FAIL reset_restart lane=%0d got=%h exp=%h last=%b", k, blk_data[64*k +: 64], e[k], blk_last);
    end
    take_blk();
  endtask

  task automatic test_shake128_short;
    logic [24:0][63:0] e;
    bit ok, good;
    int k;
    send_word(64'h0706050403020100, 1'b1, 4'd3, 1'b0, good);
    checks++;
    if (blk_valid !== 1'b1 || in_ready !== 1'b0 || !good)
      begin failures++; $display("FAIL s128_latency got vld=%b rdy=%b exp 1 0", blk_valid, in_ready); end
    wait_blk(ok);
    e = '0; e[0] = 64'h0000_0000_1F02_0100; e[20] = 64'h8000_0000_0000_0000;
    checks++;
    if (blk_data !== e) begin
      failures++; k = diff_lane(blk_data, e);
      $display("FAIL s128_data lane=%0d got=%h exp=%h", k, blk_data[64*k +: 64], e[k]);
    end
    checks++;
    if (blk_last !== 1'b1) begin failures++; $display("FAIL s128_last got=%b exp=1", blk_last); end
    take_blk();
    checks++;
    if (in_ready !== 1'b1 || blk_valid !== 1'b0)
      begin failures++; $display("FAIL s128_refill got rdy=%b vld=%b exp 1 0", in_ready, blk_valid); end
  endtask

  task automatic test_back_to_back_pend;
    logic [24:0][63:0] e;
    bit ok, good;
    int k;
    good = 1'b1;
    e = '0;
    for (int i = 0; i < 17; i++) begin
      e[i] = 64'h0101_0101_0101_0101 * 64'(i + 1);
      send_word(e[i], i == 16, 4'd8, 1'b1, ok); good &= ok;
    end
    wait_blk(ok); good &= ok;
    checks++;
    if (!good) begin failures++; $display("FAIL s256_hs got=0 exp=1 (handshake timeout)"); end
    checks++;
    if (blk_data !== e || blk_last !== 1'b0) begin
      failures++; k = diff_lane(blk_data, e);
      $display("FAIL s256_blk1 lane=%0d got=%h exp=%h last=%b", k, blk_data[64*k +: 64], e[k], blk_last);
    end
    take_blk();
    checks++;
    if (blk_valid !== 1'b1 || in_ready !== 1'b0)
      begin failures++; $display("FAIL s256_padblk_vld got vld=%b rdy=%b exp 1 0", blk_valid, in_ready); end
    e = '0; e[0] = 64'h1F; e[16] = 64'h8000_0000_0000_0000;
    checks++;
    if (blk_data !== e || blk_last !== 1'b1) begin
      failures++; k = diff_lane(blk_data, e);
      $display("FAIL s256_padblk lane=%0d got=%h exp=%h last=%b", k, blk_data[64*k +: 64], e[k], blk_last);
    end
    take_blk();
  endtask

  task automatic test_overlap;
    logic [24:0][63:0] e;
    logic [63:0] d;
    bit ok, good;
    int k;
    good = 1'b1; e = '0;
    for (int i = 0; i < 21; i++) begin
      d = 64'hFEDC_BA98_7654_3210 ^ 64'(i);
      e[i] = d;
      send_word(d, i == 20, (i == 20) ? 4'd7 : 4'd8, 1'b0, ok); good &= ok;
    end
    e[20] = {8'h9F, e[20][55:0]};
    wait_blk(ok); good &= ok;
    checks++;
    if (!good || blk_data !== e || blk_last !== 1'b1) begin
      failures++; k = diff_lane(blk_data, e);
      $display("FAIL overlap lane=%0d got=%h exp=%h last=%b", k, blk_data[64*k +: 64], e[k], blk_last);
    end
    take_blk();
  endtask

  task automatic test_empty_and_mode;
    logic [24:0][63:0] e;
    bit ok, good;
    int k;
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0, 1'b1, good);
    wait_blk(ok); good &= ok;
    e = '0; e[0] = 64'h1F; e[16] = 64'h8000_0000_0000_0000;
    checks++;
    if (!good || blk_data !== e || blk_last !== 1'b1) begin
      failures++; k = diff_lane(blk_data, e);
      $display("FAIL empty lane=%0d got=%h exp=%h last=%b", k, blk_data[64*k +: 64], e[k], blk_last);
    end
    take_blk();
    e = '0;
    for (int i = 0; i < 4; i++) begin
      e[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
      send_word(e[i], i == 3, 4'd8, i != 0, ok); good &= ok;
    end
    e[4] = 64'h1F; e[20] = 64'h8000_0000_0000_0000;
    wait_blk(ok); good &= ok;
    checks++;
    if (!good || blk_data !== e || blk_last !== 1'b1) begin
      failures++; k = diff_lane(blk_data, e);
      $display("FAIL mode_toggle lane=%0d got=%h exp=%h last=%b", k, blk_data[64*k +: 64], e[k], blk_last);
    end
    take_blk();
  endtask

  task automatic test_backpressure;
    logic [24:0][63:0] e;
    bit ok, good;
    send_word(64'hAAAA_5555_AAAA_5555, 1'b1, 4'd8, 1'b1, good);
    e = '0; e[0] = 64'hAAAA_5555_AAAA_5555; e[1] = 64'h1F; e[16] = 64'h8000_0000_0000_0000;
    in_valid = 1'b1; in_data = 64'h1234; in_last = 1'b1; in_bytes = 4'd8;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || blk_valid !== 1'b1 || blk_data !== e || blk_last !== 1'b1)
        begin failures++; $display("FAIL bp_hold cyc=%0d got rdy=%b vld=%b last=%b data_ok=%b exp 0 1 1 1", c, in_ready, blk_valid, blk_last, blk_data === e); end
    end
    in_valid = 1'b0;
    take_blk();
    checks++;
    if (!good || in_ready !== 1'b1 || blk_valid !== 1'b0)
      begin failures++; $display("FAIL bp_release got rdy=%b vld=%b exp 1 0", in_ready, blk_valid); end
  endtask

  task automatic test_random;
    logic [63:0] w_dat[$];
    logic        w_last[$], w_mode[$];
    logic [3:0]  w_bytes[$];
    logic [1599:0] d, ed;
    logic l, el, v, br, acc, hs;
    int nw, nb, wi, cyc, k;
    logic [63:0] x;
    logic m;
    exp_dat.delete(); exp_last.delete();
    for (int j = 0; j < 50; j++) begin
      nw = $urandom_range(1, 24); nb = $urandom_range(0, 8); m = 1'($urandom_range(0, 1));
      msg.delete();
      for (int i = 0; i < nw; i++) begin
        x = {$urandom(), $urandom()};
        w_dat.push_back(x); w_last.push_back(i == nw - 1);
        w_bytes.push_back((i == nw - 1) ? 4'(nb) : 4'(8));
        w_mode.push_back((i == 0) ? m : 1'($urandom_range(0, 1)));
        for (int b = 0; b < ((i == nw - 1) ? nb : 8); b++) msg.push_back(x[8*b +: 8]);
      end
      model(m ? 17 : 21);
    end
    wi = 0; cyc = 0;
    while ((wi < w_dat.size() || exp_dat.size() > 0) && cyc < 20000) begin
      v = (wi < w_dat.size()) && ($urandom_range(0, 3) != 0);
      in_valid = v;
      if (wi < w_dat.size()) begin
        in_data = w_dat[wi]; in_last = w_last[wi]; in_bytes = w_bytes[wi]; mode = w_mode[wi];
      end
      br = ($urandom_range(0, 2) != 0); blk_ready = br;
      acc = v && in_ready; hs = blk_valid && br; d = blk_data; l = blk_last;
      @(posedge clk); #1;
      cyc++;
      if (acc) wi++;
      if (hs) begin
        checks++;
        if (exp_dat.size() == 0) begin
          failures++; $display("FAIL rand_extra got=block exp=none");
        end else begin
          ed = exp_dat.pop_front(); el = exp_last.pop_front();
          if (d !== ed || l !== el) begin
            failures++; k = diff_lane(d, ed);
            $display("FAIL rand_blk lane=%0d got=%h exp=%h last=%b exp_last=%b", k, d[64*k +: 64], ed[64*k +: 64], l, el);
          end
        end
      end
    end
    in_valid = 1'b0; blk_ready = 1'b0;
    checks++;
    if (wi != w_dat.size() || exp_dat.size() != 0)
      begin failures++; $display("FAIL rand_drain got words=%0d blocks_left=%0d exp words=%0d blocks_left=0", wi, exp_dat.size(), w_dat.size()); end
  endtask

  initial begin
    test_reset();
    test_shake128_short();
    test_back_to_back_pend();
    test_overlap();
    test_empty_and_mode();
    test_backpressure();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
